gf2m_arith_unit: RTL and testbench

GF2M_ARITH_UNIT -- requirements
Module: gf2m_arith_unit

---
 rtl/gf2m_arith_unit.sv | 152 +++++++++++++++
 tb/tb_gf2m_arith_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_arith_unit.sv
// GF(2^M) arithmetic unit: bit-serial MSB-first multiply, single-cycle
// square-and-reduce, and their combinations (MUL, SQR, MSQR, MULSQR).
module gf2m_arith_unit #(
    parameter int             M    = 163,
    parameter logic [M-1:0]   POLY = 163'hC9,
    parameter int             KW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [KW-1:0] k,
    input  logic [M-1:0]  A,
    input  logic [M-1:0]  B,
    output logic [M-1:0]  C,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(M);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_SQR    = 2'b01;
    localparam logic [1:0] OP_MSQR   = 2'b10;
    localparam logic [1:0] OP_MULSQR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SQ, S_FIN} state_t;

    state_t          state_reg;
    logic [M-1:0]    z_reg;
    logic [M-1:0]    a_reg;
    logic [M-1:0]    b_reg;
    logic [1:0]      op_reg;
    logic [KW-1:0]   k_reg;
    logic [CW-1:0]   bit_cnt_reg;
    logic [KW-1:0]   sq_cnt_reg;

    logic [M-1:0]    z_shift;
    logic [M-1:0]    z_mul_next;
    logic [2*M-2:0]  sq_wide;
    logic [2*M-2:0]  sq_red;
    logic [M-1:0]    z_sq_next;

    // One interleaved multiply step: Z*x mod f, then add A when the current B bit is set
    always_comb begin
        z_shift    = {z_reg[M-2:0], 1'b0} ^ (z_reg[M-1] ? POLY : '0);
        z_mul_next = z_shift ^ (b_reg[bit_cnt_reg] ? a_reg : '0);
    end

    // Squaring in GF(2) is just spreading the bits onto even positions
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_spread_even
            assign sq_wide[2*gi] = z_reg[gi];
        end
        for (genvar gi = 0; gi < M - 1; gi++) begin : g_spread_odd
            assign sq_wide[2*gi+1] = 1'b0;
        end
    endgenerate

    // Fold the high half back down from the top so every term lands below degree M
    always_comb begin
        sq_red = sq_wide;
        for (int j = 2*M-2; j >= M; j--) begin
            if (sq_red[j]) begin
                sq_red[j-M +: M+1] = sq_red[j-M +: M+1] ^ {1'b1, POLY};
            end
        end
        z_sq_next = sq_red[M-1:0];
    end

    // Control FSM with registered result, busy and done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            z_reg       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= OP_MUL;
            k_reg       <= '0;
            bit_cnt_reg <= '0;
            sq_cnt_reg  <= '0;
            C           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        op_reg <= op;
                        k_reg  <= k;
                        busy   <= 1'b1;
                        case (op)
                            OP_MUL, OP_MULSQR: begin
                                z_reg       <= '0;
                                bit_cnt_reg <= CW'(M-1);
                                state_reg   <= S_MUL;
                            end
                            OP_SQR: begin
                                z_reg      <= A;
                                sq_cnt_reg <= KW'(1);
                                state_reg  <= S_SQ;
                            end
                            default: begin
                                z_reg      <= A;
                                sq_cnt_reg <= k;
                                // k=0 still needs one cycle: park in FIN to deliver A
                                state_reg  <= (k == '0) ? S_FIN : S_SQ;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    z_reg <= z_mul_next;
                    if (bit_cnt_reg == '0) begin
                        if (op_reg == OP_MULSQR && k_reg != '0) begin
                            sq_cnt_reg <= k_reg;
                            state_reg  <= S_SQ;
                        end else begin
                            C         <= z_mul_next;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                    end
                end
                S_SQ: begin
                    z_reg <= z_sq_next;
                    if (sq_cnt_reg == KW'(1)) begin
                        C         <= z_sq_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        sq_cnt_reg <= sq_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    C         <= z_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_arith_unit.sv
// Self-checking bench for gf2m_arith_unit with a queue-based scoreboard.
module tb_gf2m_arith_unit;

    localparam int           M    = 163;
    localparam int           KW   = 8;
    localparam logic [M-1:0] POLY = 163'hC9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [KW-1:0] k;
    logic [M-1:0]  A;
    logic [M-1:0]  B;
    logic [M-1:0]  C;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [M-1:0] c;
        int           lat;
    } exp_t;
    exp_t exp_q[$];

    gf2m_arith_unit #(.M(M), .POLY(POLY), .KW(KW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .k     (k),
        .A     (A),
        .B     (B),
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: LSB-first shift-and-add multiply
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r = '0;
        logic [M-1:0] t = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ t;
            t = t[M-1] ? ({t[M-2:0], 1'b0} ^ POLY) : {t[M-2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [M-1:0] gf_pow2k(input logic [M-1:0] a, input int kk);
        logic [M-1:0] r = a;
        for (int i = 0; i < kk; i++) r = gf_mul(r, r);
        return r;
    endfunction

    function automatic logic [M-1:0] rand_elem();
        logic [191:0] w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[M-1:0];
    endfunction

    // Drive one operation, push its expectation, then watch for done and score it
    task automatic do_op(input logic [1:0] op_i, input logic [M-1:0] a_i, input logic [M-1:0] b_i,
                         input int k_i, input logic [M-1:0] exp_c, input string tag, input bit pulse_busy);
        int   lat;
        int   cycles;
        bit   busy_ok;
        exp_t e;
        case (op_i)
            2'b00:   lat = M;
            2'b01:   lat = 1;
            2'b10:   lat = (k_i == 0) ? 1 : k_i;
            default: lat = M + k_i;
        endcase
        exp_q.push_back('{c: exp_c, lat: lat});
        @(negedge clk);
        start = 1'b1;
        op    = op_i;
        A     = a_i;
        B     = b_i;
        k     = KW'(k_i);
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = rand_elem();
        B     = rand_elem();
        op    = 2'($urandom);
        k     = KW'($urandom);
        cycles  = 0;
        busy_ok = 1'b1;
        while (1) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (cycles > M + 300) break;
            start = (pulse_busy && (cycles % 20 == 5)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check_val({tag, "_busy"}, M'(busy_ok), M'(1));
        check_val({tag, "_lat"}, M'(cycles), M'(e.lat));
        check_val({tag, "_C"}, C, e.c);
        check_val({tag, "_busy_clr"}, M'(busy), M'(0));
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, M'(done), M'(0));
        $display("op=%0d tag=%s C=%h cycles=%0d", op_i, tag, C, cycles);
    endtask

    initial begin
        logic [M-1:0] x162;
        logic [M-1:0] ra;
        logic [M-1:0] rb;
        logic [1:0]   rop;
        int           rk;
        logic [M-1:0] rexp;
        bit           done_seen;

        x162  = '0;
        x162[162] = 1'b1;
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        k     = '0;
        A     = '0;
        B     = '0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_C", C, '0);
        check_val("rst_busy", M'(busy), M'(0));
        check_val("rst_done", M'(done), M'(0));
        @(negedge clk);
        rst = 1'b1;

        do_op(2'b00, M'(1), M'(1), 0, M'(1), "mul_1x1", 1'b0);
        do_op(2'b00, x162, M'(2), 0, M'(163'hC9), "mul_red", 1'b0);
        do_op(2'b01, x162, '0, 0, (M'(1) << 161) | M'(163'h1422), "sqr_x162", 1'b0);
        do_op(2'b01, M'(2), '0, 0, M'(4), "sqr_2", 1'b0);
        do_op(2'b10, M'(2), '0, 3, M'(163'h100), "msqr_k3", 1'b0);
        do_op(2'b10, M'(5), '0, 0, M'(5), "msqr_k0", 1'b0);
        do_op(2'b11, x162, M'(2), 1, M'(163'h5041), "mulsqr_ign", 1'b1);

        for (int i = 0; i < 5; i++) begin
            ra   = rand_elem();
            rb   = rand_elem();
            rop  = 2'($urandom);
            rk   = $urandom_range(0, 5);
            case (rop)
                2'b00:   rexp = gf_mul(ra, rb);
                2'b01:   rexp = gf_mul(ra, ra);
                2'b10:   rexp = gf_pow2k(ra, rk);
                default: rexp = gf_pow2k(gf_mul(ra, rb), rk);
            endcase
            do_op(rop, ra, rb, rk, rexp, "rand", 1'b0);
        end

        // start held high: relaunch on the edge after done
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        A     = M'(2);
        B     = '0;
        k     = '0;
        @(posedge clk);
        #1;
        check_val("hold_busy0", M'(busy), M'(1));
        @(posedge clk);
        #1;
        check_val("hold_done0", M'(done), M'(1));
        check_val("hold_C0", C, M'(4));
        A = M'(3);
        @(posedge clk);
        #1;
        check_val("hold_busy1", M'(busy), M'(1));
        check_val("hold_nodone1", M'(done), M'(0));
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val("hold_done1", M'(done), M'(1));
        check_val("hold_C1", C, M'(5));
        $display("held-start relaunch C=%h", C);

        // reset mid-multiply aborts the operation
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        A     = rand_elem();
        B     = rand_elem();
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("abort_C", C, '0);
        check_val("abort_busy", M'(busy), M'(0));
        check_val("abort_done", M'(done), M'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check_val("abort_no_done", M'(done_seen), M'(0));
        check_val("abort_C_hold", C, '0);
        $display("reset abort done_seen=%0d", done_seen);

        do_op(2'b00, M'(3), M'(3), 0, M'(5), "mul_after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
